// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    localparam int LEN_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

    // States in which the loader consumes stream bytes.
    function automatic logic is_rx_state(input loader_state_e s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int WIDTH = 32
) ();
    logic             rxValid;
    logic [7:0]       rxData;
    logic             rxReady;
    logic             insMemEn;
    logic [WIDTH-1:0] insMemAddr;
    logic [WIDTH-1:0] insMemDataIn;

    // master: byte source / memory side; slave: the loader itself.
    modport master (
        output rxValid, rxData,
        input  rxReady, insMemEn, insMemAddr, insMemDataIn
    );

    modport slave (
        input  rxValid, rxData,
        output rxReady, insMemEn, insMemAddr, insMemDataIn
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian stream bytes into words and keeps the running 8-bit checksum.
module loader_word_assembler
    import imem_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [7:0]       i_byte,
    output logic [WIDTH-1:0] o_word,
    output logic             o_word_done,
    output logic [7:0]       o_csum
);
    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_word;
    logic [7:0]       r_csum;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_idx  <= '0;
            r_word <= '0;
            r_csum <= '0;
        end else if (i_valid) begin
            r_word[{r_idx, 3'b000} +: 8] <= i_byte;
            r_idx                        <= r_idx + IDX_W'(1);
            r_csum                       <= r_csum + i_byte;
        end
    end

    assign o_word      = r_word;
    assign o_word_done = i_valid && (r_idx == IDX_W'(BYTES_PER_WORD - 1));
    assign o_csum      = r_csum;
endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> instruction-memory writes; holds the core in reset until verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter int               IMEM_DEPTH     = 512,
    parameter logic [WIDTH-1:0] BASE_ADDR      = '0,
    parameter int               TIMEOUT_CYCLES = 100000
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_start,
    imem_loader_if.slave  bus,
    output logic          o_cpuReset,
    output logic          o_done,
    output logic          o_error,
    output logic [1:0]    o_errCode
);
    localparam int             MAX_WORDS = IMEM_DEPTH / 4;
    localparam int             TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_INIT = TMO_W'(TIMEOUT_CYCLES - 1);

    loader_state_e    r_state, w_next;
    logic [31:0]      r_len;
    logic [1:0]       r_len_idx;
    logic [31:0]      r_word_cnt;
    logic [WIDTH-1:0] r_addr;
    logic [TMO_W-1:0] r_tmo;
    logic [1:0]       r_err_code, w_err_code;

    logic             w_rx_state, w_accept, w_start_ok, w_tmo_hit, w_last_word;
    logic [31:0]      w_len_full;
    logic [WIDTH-1:0] w_asm_word;
    logic             w_word_done;
    logic [7:0]       w_csum;

    assign w_rx_state  = is_rx_state(r_state);
    assign w_accept    = bus.rxValid && w_rx_state;
    assign w_start_ok  = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_len_full  = {bus.rxData, r_len[31:8]};
    assign w_last_word = (r_word_cnt + 32'd1) == r_len;
    // Down-counter reloads on every accept; hitting zero on an idle cycle is the timeout.
    assign w_tmo_hit   = w_rx_state && !w_accept && (r_tmo == '0);

    loader_word_assembler #(.WIDTH(WIDTH)) u_asm (
        .i_clk       (i_clock),
        .i_rst       (i_reset),
        .i_clear     (w_start_ok),
        .i_valid     (w_accept && (r_state == ST_DATA)),
        .i_byte      (bus.rxData),
        .o_word      (w_asm_word),
        .o_word_done (w_word_done),
        .o_csum      (w_csum)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_err_code = r_err_code;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (i_start) begin
                    w_next     = ST_LEN;
                    w_err_code = ERR_NONE;
                end
            end
            ST_LEN: begin
                if (w_accept && (r_len_idx == 2'(LEN_BYTES - 1))) begin
                    if (w_len_full == 32'd0) begin
                        w_next = ST_CSUM;
                    end else if (w_len_full > 32'(MAX_WORDS)) begin
                        w_next     = ST_ERR;
                        w_err_code = ERR_LEN;
                    end else begin
                        w_next = ST_DATA;
                    end
                end else if (w_tmo_hit) begin
                    w_next     = ST_ERR;
                    w_err_code = ERR_TIMEOUT;
                end
            end
            ST_DATA: begin
                if (w_word_done) begin
                    w_next = ST_WRITE;
                end else if (w_tmo_hit) begin
                    w_next     = ST_ERR;
                    w_err_code = ERR_TIMEOUT;
                end
            end
            ST_WRITE: w_next = w_last_word ? ST_CSUM : ST_DATA;
            ST_CSUM: begin
                if (w_accept) begin
                    if (bus.rxData == w_csum) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next     = ST_ERR;
                        w_err_code = ERR_CSUM;
                    end
                end else if (w_tmo_hit) begin
                    w_next     = ST_ERR;
                    w_err_code = ERR_TIMEOUT;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_addr     <= BASE_ADDR;
            r_len      <= '0;
            r_len_idx  <= '0;
            r_word_cnt <= '0;
            r_tmo      <= TMO_INIT;
            r_err_code <= ERR_NONE;
        end else begin
            r_err_code <= w_err_code;
            if (w_start_ok) begin
                r_addr     <= BASE_ADDR;
                r_len      <= '0;
                r_len_idx  <= '0;
                r_word_cnt <= '0;
                r_tmo      <= TMO_INIT;
            end else begin
                if ((r_state == ST_LEN) && w_accept) begin
                    r_len     <= w_len_full;
                    r_len_idx <= r_len_idx + 2'd1;
                end
                if (r_state == ST_WRITE) begin
                    r_addr     <= r_addr + WIDTH'(4);
                    r_word_cnt <= r_word_cnt + 32'd1;
                end
                if (w_accept)                       r_tmo <= TMO_INIT;
                else if (w_rx_state && r_tmo != '0) r_tmo <= r_tmo - TMO_W'(1);
            end
        end
    end

    assign bus.rxReady      = w_rx_state;
    assign bus.insMemEn     = (r_state == ST_WRITE);
    assign bus.insMemAddr   = r_addr;
    assign bus.insMemDataIn = w_asm_word;
    assign o_cpuReset       = (r_state != ST_DONE);
    assign o_done           = (r_state == ST_DONE);
    assign o_error          = (r_state == ST_ERR);
    assign o_errCode        = r_err_code;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, length/checksum/timeout errors, mid-load reset.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cpu_reset, done, error;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    imem_loader_if #(.WIDTH(32)) bus ();

    imem_loader #(
        .WIDTH          (32),
        .IMEM_DEPTH     (512),
        .BASE_ADDR      (32'h0),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_start    (start),
        .bus        (bus),
        .o_cpuReset (cpu_reset),
        .o_done     (done),
        .o_error    (error),
        .o_errCode  (err_code)
    );

    always #5 clk = ~clk;

    // Observation at the falling edge: accepts, write pulses and protocol violations.
    int          cyc = 0;
    int          acc_count = 0;
    int          wr_count = 0;
    int          bad_en = 0;
    int          bad_ready = 0;
    logic        prev_en = 1'b0;
    int          acc_cyc [64];
    int          en_cyc  [64];
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];

    always @(negedge clk) begin
        cyc++;
        if (bus.rxValid && bus.rxReady) begin
            if (acc_count < 64) acc_cyc[acc_count] = cyc;
            acc_count++;
        end
        if (bus.insMemEn) begin
            if (wr_count < 64) begin
                en_cyc[wr_count]  = cyc;
                wr_addr[wr_count] = bus.insMemAddr;
                wr_data[wr_count] = bus.insMemDataIn;
            end
            wr_count++;
            if (prev_en) bad_en++;
            if (bus.rxReady) bad_ready++;
        end
        prev_en = bus.insMemEn;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that consumed the byte.
    task automatic send_byte(input logic [7:0] b);
        logic seen;
        seen = 1'b0;
        bus.rxValid = 1'b1;
        bus.rxData  = b;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.rxReady) begin
                seen = 1'b1;
                break;
            end
        end
        check("rx_ready_wait", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic rx_idle();
        bus.rxValid = 1'b0;
        bus.rxData  = 8'h00;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rxReady"}, {31'd0, bus.rxReady}, 32'd0);
        check({tag, "_en"},      {31'd0, bus.insMemEn}, 32'd0);
        check({tag, "_addr"},    bus.insMemAddr, 32'h0);
        check({tag, "_data"},    bus.insMemDataIn, 32'h0);
        check({tag, "_cpuRst"},  {31'd0, cpu_reset}, 32'd1);
        check({tag, "_done"},    {31'd0, done}, 32'd0);
        check({tag, "_error"},   {31'd0, error}, 32'd0);
        check({tag, "_errCode"}, {30'd0, err_code}, 32'd0);
    endtask

    int acc0, wr0;

    initial begin
        rx_idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_values("rst");

        // N=2: 0x00000013, 0x00100093; byte sum 0x13+0x93+0x10 = 0xB6.
        acc0 = acc_count; wr0 = wr_count;
        pulse_start();
        check("t1_ready_len", {31'd0, bus.rxReady}, 32'd1);
        send_len(32'd2);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        check("t1_cpuRst_pre", {31'd0, cpu_reset}, 32'd1);
        check("t1_done_pre",   {31'd0, done}, 32'd0);
        send_byte(8'hB6);
        rx_idle();
        check("t1_done",    {31'd0, done}, 32'd1);
        check("t1_cpuRst",  {31'd0, cpu_reset}, 32'd0);
        check("t1_error",   {31'd0, error}, 32'd0);
        check("t1_ready",   {31'd0, bus.rxReady}, 32'd0);
        check("t1_nwr",     wr_count - wr0, 32'd2);
        check("t1_addr0",   wr_addr[wr0], 32'h0);
        check("t1_data0",   wr_data[wr0], 32'h0000_0013);
        check("t1_addr1",   wr_addr[wr0+1], 32'h4);
        check("t1_data1",   wr_data[wr0+1], 32'h0010_0093);
        check("t1_naccept", acc_count - acc0, 32'd13);
        // 8th accepted byte closes word 0: strobe next cycle, next byte the cycle after.
        check("t1_lat_en",   en_cyc[wr0] - acc_cyc[acc0+7], 32'd1);
        check("t1_lat_next", acc_cyc[acc0+8] - en_cyc[wr0], 32'd1);

        // Restart from DONE with an oversize length (129 words).
        acc0 = acc_count; wr0 = wr_count;
        pulse_start();
        check("t2_cpuRst_len", {31'd0, cpu_reset}, 32'd1);
        check("t2_done_clr",   {31'd0, done}, 32'd0);
        send_len(32'd129);
        rx_idle();
        check("t2_error",   {31'd0, error}, 32'd1);
        check("t2_errCode", {30'd0, err_code}, 32'd1);
        check("t2_cpuRst",  {31'd0, cpu_reset}, 32'd1);
        check("t2_nwr",     wr_count - wr0, 32'd0);
        check("t2_naccept", acc_count - acc0, 32'd4);

        // Bad checksum: 0xDEADBEEF sums to 0x38, send 0x00.
        acc0 = acc_count; wr0 = wr_count;
        pulse_start();
        check("t3_errCode_clr", {30'd0, err_code}, 32'd0);
        send_len(32'd1);
        send_word(32'hDEAD_BEEF);
        send_byte(8'h00);
        rx_idle();
        check("t3_nwr",     wr_count - wr0, 32'd1);
        check("t3_addr",    wr_addr[wr0], 32'h0);
        check("t3_data",    wr_data[wr0], 32'hDEAD_BEEF);
        check("t3_error",   {31'd0, error}, 32'd1);
        check("t3_errCode", {30'd0, err_code}, 32'd3);
        check("t3_done",    {31'd0, done}, 32'd0);
        check("t3_naccept", acc_count - acc0, 32'd9);

        // Empty image: N=0, checksum of no bytes is 0.
        acc0 = acc_count; wr0 = wr_count;
        pulse_start();
        send_len(32'd0);
        send_byte(8'h00);
        rx_idle();
        check("t4_done",    {31'd0, done}, 32'd1);
        check("t4_nwr",     wr_count - wr0, 32'd0);
        check("t4_naccept", acc_count - acc0, 32'd5);

        // Timeout: stall after two data bytes, error exactly 16 cycles after last accept.
        pulse_start();
        send_len(32'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        rx_idle();
        repeat (15) @(posedge clk);
        #1;
        check("t5_error_early", {31'd0, error}, 32'd0);
        @(posedge clk);
        #1;
        check("t5_error",   {31'd0, error}, 32'd1);
        check("t5_errCode", {30'd0, err_code}, 32'd2);

        // Reset after 5 data bytes of a 2-word image, then a clean 1-word load.
        wr0 = wr_count;
        pulse_start();
        send_len(32'd2);
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        rx_idle();
        check("t6_partial_nwr",  wr_count - wr0, 32'd1);
        check("t6_partial_data", wr_data[wr0], 32'h0403_0201);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset_values("t6_rst");
        wr0 = wr_count;
        pulse_start();
        send_len(32'd1);
        send_word(32'h1234_5678);
        send_byte(8'h14);
        rx_idle();
        check("t6_nwr",  wr_count - wr0, 32'd1);
        check("t6_addr", wr_addr[wr0], 32'h0);
        check("t6_data", wr_data[wr0], 32'h1234_5678);
        check("t6_done", {31'd0, done}, 32'd1);

        check("en_back_to_back", bad_en, 32'd0);
        check("ready_in_write",  bad_ready, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
